// File: rtl/divu_pkg.sv
// Shared types and constants for the DIVU/MFHI/MFLO multicycle divider.
package divu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } divu_state_e;

  localparam int DIVU_WIDTH = 32;
  localparam int DIVU_CNT_W = 6;

  // Decoder funct fields that drive the issue strobes
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  localparam logic [DIVU_WIDTH-1:0] DIV_ZERO_QUOT = {DIVU_WIDTH{1'b1}};

endpackage

// File: rtl/divu_if.sv
// Datapath <-> divide sequencer bundle: issue strobes, operands, stall and HI/LO results.
interface divu_if
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
);

  logic             div_issue;
  logic             mfhi_issue;
  logic             mflo_issue;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mfx_result;
  logic             mfx_sel;

  modport master (
    output div_issue, mfhi_issue, mflo_issue, dividend, divisor,
    input  stall, busy, hi, lo, mfx_result, mfx_sel
  );

  modport slave (
    input  div_issue, mfhi_issue, mflo_issue, dividend, divisor,
    output stall, busy, hi, lo, mfx_result, mfx_sel
  );

endinterface

// File: rtl/divu_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
module divu_step
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH-1:0] rem_sh_s;
  logic             ge_s;

  // Shifted-out MSB of rem is bit WIDTH of the trial; if set the trial is non-negative
  always_comb begin
    rem_sh_s = {rem[WIDTH-2:0], quo[WIDTH-1]};
    ge_s     = rem[WIDTH-1] | (rem_sh_s >= divisor);
    if (ge_s) begin
      rem_next = rem_sh_s - divisor;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh_s;
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divu_sequencer.sv
// DIVU controller: captures operands, iterates one quotient bit per cycle, owns HI/LO and stall.
// Optional DIVU_EARLY_OUT_EN: dividend < divisor skips the iteration phase.
module divu_sequencer
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH,
  parameter int CNT_W = DIVU_CNT_W
) (
  input  logic   clk,
  input  logic   reset,
  divu_if.slave  bus
);

  divu_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] rem_r, rem_nxt_s;
  logic [WIDTH-1:0] quo_r, quo_nxt_s;
  logic [WIDTH-1:0] dvsr_r, dvsr_nxt_s;
  logic [WIDTH-1:0] hi_r, hi_nxt_s;
  logic [WIDTH-1:0] lo_r, lo_nxt_s;
  logic [WIDTH-1:0] step_rem_s, step_quo_s;
  logic             busy_s, stall_s, mfx_sel_s;
  logic [WIDTH-1:0] mfx_result_s;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath next values; HI/LO move only on completion or divide-by-zero
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rem_nxt_s   = rem_r;
    quo_nxt_s   = quo_r;
    dvsr_nxt_s  = dvsr_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (bus.div_issue) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            hi_nxt_s = bus.dividend;
            lo_nxt_s = {WIDTH{1'b1}};
          end
`ifdef DIVU_EARLY_OUT_EN
          else if (bus.dividend < bus.divisor) begin
            hi_nxt_s = bus.dividend;
            lo_nxt_s = {WIDTH{1'b0}};
          end
`endif
          else begin
            dvsr_nxt_s  = bus.divisor;
            quo_nxt_s   = bus.dividend;
            rem_nxt_s   = {WIDTH{1'b0}};
            cnt_nxt_s   = CNT_W'(WIDTH);
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        rem_nxt_s = step_rem_s;
        quo_nxt_s = step_quo_s;
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          hi_nxt_s    = step_rem_s;
          lo_nxt_s    = step_quo_s;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Iteration and architectural result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
      quo_r  <= {WIDTH{1'b0}};
      dvsr_r <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      cnt_r  <= cnt_nxt_s;
      rem_r  <= rem_nxt_s;
      quo_r  <= quo_nxt_s;
      dvsr_r <= dvsr_nxt_s;
      hi_r   <= hi_nxt_s;
      lo_r   <= lo_nxt_s;
    end
  end

  // Stall any instruction that would observe or clobber an unfinished result
  always_comb begin
    busy_s    = (state_r == RUN);
    stall_s   = busy_s & (bus.div_issue | bus.mfhi_issue | bus.mflo_issue);
    mfx_sel_s = (bus.mfhi_issue | bus.mflo_issue) & ~stall_s;
    if (bus.mfhi_issue) begin
      mfx_result_s = hi_r;
    end else begin
      mfx_result_s = lo_r;
    end
  end

  assign bus.busy       = busy_s;
  assign bus.stall      = stall_s;
  assign bus.mfx_sel    = mfx_sel_s;
  assign bus.mfx_result = mfx_result_s;
  assign bus.hi         = hi_r;
  assign bus.lo         = lo_r;

endmodule

// File: tb/tb_divu_sequencer.sv
// Directed bench for divu_sequencer: vector table plus stall, back-to-back and reset sequences.
module tb_divu_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  divu_if #(.WIDTH(32)) bus ();

  divu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Count busy cycles at negedges until busy drops (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r);
    int n;
    int exp_busy;
    exp_busy = (b == 32'd0) ? 0 : 32;
`ifdef DIVU_EARLY_OUT_EN
    if (b != 32'd0 && a < b) exp_busy = 0;
`endif
    @(posedge clk); #1;
    bus.div_issue = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge clk);
    check({name, "_issue_stall"}, {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.div_issue = 1'b0;
    wait_idle(n);
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_lo"}, bus.lo, q);
    check({name, "_hi"}, bus.hi, r);
    bus.mflo_issue = 1'b1;
    #1;
    check({name, "_mflo_sel"}, {31'd0, bus.mfx_sel}, 32'd1);
    check({name, "_mflo_res"}, bus.mfx_result, q);
    bus.mflo_issue = 1'b0;
    bus.mfhi_issue = 1'b1;
    #1;
    check({name, "_mfhi_res"}, bus.mfx_result, r);
    bus.mfhi_issue = 1'b0;
  endtask

  initial begin
    int n;
    logic bad_sel;
    logic bad_hi;
    logic [31:0] hi_prev;

    checks = 0;
    errors = 0;
    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'h10,         q: 32'h0FFF_FFFF,  r: 32'hF};
    vecs[2] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234};
    vecs[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0};
    vecs[6] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2};
    vecs[7] = '{a: 32'd12345678,   b: 32'd1000,       q: 32'd12345,      r: 32'd678};
    vecs[8] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0};
    vecs[9] = '{a: 32'h8000_0001,  b: 32'h8000_0000,  q: 32'd1,          r: 32'd1};

    reset          = 1'b0;
    bus.div_issue  = 1'b0;
    bus.mfhi_issue = 1'b0;
    bus.mflo_issue = 1'b0;
    bus.dividend   = 32'd0;
    bus.divisor    = 32'd0;
    #12;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // MFHI presented at cycle 5 of 0xFFFFFFFF/0x10 must stall through cycle 32
    @(posedge clk); #1;
    bus.div_issue = 1'b1;
    bus.dividend  = 32'hFFFF_FFFF;
    bus.divisor   = 32'h10;
    @(posedge clk); #1;
    bus.div_issue = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.mfhi_issue = 1'b1;
    hi_prev = bus.hi;
    bad_sel = 1'b0;
    bad_hi  = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.stall) begin
        n++;
        if (bus.mfx_sel) bad_sel = 1'b1;
        if (bus.hi !== hi_prev) bad_hi = 1'b1;
      end else begin
        break;
      end
    end
    check("mfhi_stall_cycles", n, 32'd28);
    check("mfhi_sel_during_stall", {31'd0, bad_sel}, 32'd0);
    check("mfhi_hi_moved_in_run", {31'd0, bad_hi}, 32'd0);
    check("mfhi_sel", {31'd0, bus.mfx_sel}, 32'd1);
    check("mfhi_res", bus.mfx_result, 32'hF);
    check("mfhi_lo", bus.lo, 32'h0FFF_FFFF);
    bus.mfhi_issue = 1'b0;

    // Back-to-back DIVU: second is held until the first completes
    @(posedge clk); #1;
    bus.div_issue = 1'b1;
    bus.dividend  = 32'd50;
    bus.divisor   = 32'd5;
    @(posedge clk); #1;
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd4;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.stall) n++;
      else break;
    end
    check("b2b_stall_cycles", n, 32'd32);
    check("b2b_mid_lo", bus.lo, 32'd10);
    check("b2b_mid_hi", bus.hi, 32'd0);
    @(posedge clk); #1;
    bus.div_issue = 1'b0;
    wait_idle(n);
    check("b2b_busy_cycles", n, 32'd32);
    check("b2b_lo", bus.lo, 32'd2);
    check("b2b_hi", bus.hi, 32'd1);

    // Asynchronous reset at cycle 10 of a divide
    @(posedge clk); #1;
    bus.div_issue = 1'b1;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(posedge clk); #1;
    bus.div_issue = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.mflo_issue = 1'b1;
    #1;
    check("prerst_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall}, 32'd0);
    bus.mflo_issue = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_div("post_rst", 32'd8, 32'd3, 32'd2, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
